// File: rtl/spi_pkg.sv
// Shared constants for the sclk-domain SPI slave: status bit positions and
// default frame geometry.
package spi_pkg;

    localparam int STAT_UNDERRUN = 0;
    localparam int STAT_OVERRUN  = 1;
    localparam int STAT_ABORT    = 2;

    localparam int         DEF_DATA_W    = 8;
    localparam int         DEF_DEPTH     = 4;
    localparam logic [7:0] DEF_IDLE_WORD = 8'hFF;

endpackage

// File: rtl/spi_tx_fifo.sv
// Transmit word FIFO for the SPI slave. It shows the head word combinationally
// so the first bit of a frame can leave before the pop edge.
module spi_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       sclk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A full FIFO refuses the write even when a pop lands in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge sclk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/spi_slave_buf.sv
// SPI slave clocked by sclk. It shifts frames out of a TX FIFO, latches received
// words into a valid/ack holding register and keeps sticky error status.
module spi_slave_buf
    import spi_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                DEPTH     = DEF_DEPTH,
    parameter bit                MSB_FIRST = 1'b1,
    parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(DEF_IDLE_WORD)
) (
    input  logic                       sclk,
    input  logic                       rst,
    input  logic                       select,
    input  logic                       MOSI,
    output logic                       MISO,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       write_en,
    output logic                       tx_ready,
    output logic [DATA_W-1:0]          data_out,
    output logic                       rx_valid,
    input  logic                       read_en,
    output logic [$clog2(DEPTH+1)-1:0] tx_count,
    output logic                       busy,
    output logic [2:0]                 status,
    input  logic                       status_clr
);
    localparam int                BIT_W    = $clog2(DATA_W);
    localparam int                OUT_BIT  = MSB_FIRST ? DATA_W - 1 : 0;
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);

    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] fifo_head;
    logic [DATA_W-1:0] tx_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic              frame_start;
    logic              frame_done;
    logic [2:0]        stat_set;

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    spi_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_tx_fifo (
        .sclk    (sclk),
        .rst     (rst),
        .push    (write_en),
        .pop     (frame_start),
        .data_in (data_in),
        .head    (fifo_head),
        .count   (tx_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tx_ready    = !fifo_full;
    assign busy        = (bit_cnt != '0);
    assign frame_start = select && !busy;
    assign frame_done  = select && (bit_cnt == LAST_BIT);
    assign tx_word     = fifo_empty ? IDLE_WORD : fifo_head;
    assign rx_next     = MSB_FIRST ? {rx_shift[DATA_W-2:0], MOSI}
                                   : {MOSI, rx_shift[DATA_W-1:1]};

    // The first bit comes straight from the word about to be loaded.
    assign MISO = !select ? 1'b0 : (busy ? tx_shift[OUT_BIT] : tx_word[OUT_BIT]);

    always_comb begin
        stat_set                = '0;
        stat_set[STAT_UNDERRUN] = frame_start && fifo_empty;
        stat_set[STAT_OVERRUN]  = frame_done && rx_valid && !read_en;
        stat_set[STAT_ABORT]    = !select && busy;
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            data_out <= '0;
            rx_valid <= 1'b0;
            status   <= '0;
        end else begin
            if (select) begin
                rx_shift <= rx_next;
                if (!busy) begin
                    tx_shift <= shift_out(tx_word);
                    bit_cnt  <= BIT_W'(1);
                end else begin
                    tx_shift <= shift_out(tx_shift);
                    bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
                end
            end else if (busy) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end

            if (frame_done) begin
                data_out <= rx_next;
                rx_valid <= 1'b1;
            end else if (read_en && rx_valid) begin
                rx_valid <= 1'b0;
            end

            status <= (status_clr ? 3'b000 : status) | stat_set;
        end
    end

endmodule
